// File: rtl/muldiv_pkg.sv
// Shared func codes, FSM encoding and default operand width for the HI/LO muldiv unit.
// Imported by the interface, the iterative core and the controller.
package muldiv_pkg;
    localparam int WIDTH_DEF = 32;

    localparam logic [5:0] FN_MFHI  = 6'b010000;
    localparam logic [5:0] FN_MTHI  = 6'b010001;
    localparam logic [5:0] FN_MFLO  = 6'b010010;
    localparam logic [5:0] FN_MTLO  = 6'b010011;
    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_DIV   = 6'b011010;
    localparam logic [5:0] FN_DIVU  = 6'b011011;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FIXUP = 2'd2
    } state_e;
endpackage

// File: rtl/muldiv_hilo_ctrl_if.sv
// Execute-stage <-> muldiv unit bundle: op request/handshake in, stall/busy/read data and HI/LO out.
// master = execute stage, slave = muldiv controller.
interface muldiv_hilo_ctrl_if
    import muldiv_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
);
    logic             enable_execute;
    logic             op_valid;
    logic [5:0]       op_func;
    logic [WIDTH-1:0] rs_val;
    logic [WIDTH-1:0] rt_val;
    logic             op_ready;
    logic             stall;
    logic             busy;
    logic [WIDTH-1:0] rd_data;
    logic             rd_valid;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output enable_execute, op_valid, op_func, rs_val, rt_val,
        input  op_ready, stall, busy, rd_data, rd_valid, hi, lo
    );

    modport slave (
        input  enable_execute, op_valid, op_func, rs_val, rt_val,
        output op_ready, stall, busy, rd_data, rd_valid, hi, lo
    );
endinterface

// File: rtl/muldiv_iter_core.sv
// Radix-2 datapath: right-shifting shift-add multiply or left-shifting restoring divide on magnitudes.
// One step per cycle when step=1; load overrides step; no backpressure (controller sequences it).
module muldiv_iter_core
    import muldiv_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  logic             is_div,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic [WIDTH-1:0] acc_hi,
    output logic [WIDTH-1:0] acc_lo
);
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   diff;

    // acc_lo starts as multiplier (mult) or dividend (div); b holds multiplicand or divisor.
    always_comb begin
        b_d    = b_q;
        hi_d   = hi_q;
        lo_d   = lo_q;
        sum    = {1'b0, hi_q} + {1'b0, b_q};
        rem_sh = {hi_q, lo_q[WIDTH-1]};
        diff   = rem_sh - {1'b0, b_q};
        if (load) begin
            b_d  = op_b;
            hi_d = '0;
            lo_d = op_a;
        end else if (step) begin
            if (is_div) begin
                // diff[WIDTH] set means the trial subtract went negative: restore.
                if (!diff[WIDTH]) begin
                    hi_d = diff[WIDTH-1:0];
                    lo_d = {lo_q[WIDTH-2:0], 1'b1};
                end else begin
                    hi_d = rem_sh[WIDTH-1:0];
                    lo_d = {lo_q[WIDTH-2:0], 1'b0};
                end
            end else if (lo_q[0]) begin
                {hi_d, lo_d} = {sum, lo_q[WIDTH-1:1]};
            end else begin
                {hi_d, lo_d} = {1'b0, hi_q, lo_q[WIDTH-1:1]};
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            b_q  <= '0;
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            b_q  <= b_d;
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

    assign acc_hi = hi_q;
    assign acc_lo = lo_q;
endmodule

// File: rtl/muldiv_hilo_ctrl.sv
// MULT/MULTU/DIV/DIVU sequencer and HI/LO owner with MFHI/MFLO/MTHI/MTLO service.
// Latency: iterative ops WIDTH+1 cycles after fire; moves/reads 1 cycle.
// Backpressure: op_ready only in IDLE; stall = op_valid & enable_execute & ~op_ready.
module muldiv_hilo_ctrl
    import muldiv_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic                clock,
    input  logic                reset,
    muldiv_hilo_ctrl_if.slave   bus
);
    localparam int CW = $clog2(WIDTH);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] rd_data_q, rd_data_d;
    logic             rd_valid_q, rd_valid_d;
    logic             busy_q, busy_d;
    logic             ready_q, ready_d;
    logic             is_div_q, is_div_d;
    logic             neg_q, neg_d;
    logic             rem_neg_q, rem_neg_d;

    logic             fire;
    logic             is_signed;
    logic             rs_neg, rt_neg;
    logic [WIDTH-1:0] rs_mag, rt_mag;
    logic             core_load, core_step;
    logic [WIDTH-1:0] core_hi, core_lo;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0] quo_fix, rem_fix;

    muldiv_iter_core #(.WIDTH(WIDTH)) u_core (
        .clock  (clock),
        .reset  (reset),
        .load   (core_load),
        .step   (core_step),
        .is_div (is_div_q),
        .op_a   (rs_mag),
        .op_b   (rt_mag),
        .acc_hi (core_hi),
        .acc_lo (core_lo)
    );

    always_comb begin
        fire      = bus.op_valid & bus.enable_execute & ready_q;
        // Odd func codes in the muldiv group are the unsigned variants.
        is_signed = ~bus.op_func[0];
        rs_neg    = is_signed & bus.rs_val[WIDTH-1];
        rt_neg    = is_signed & bus.rt_val[WIDTH-1];
        rs_mag    = rs_neg ? -bus.rs_val : bus.rs_val;
        rt_mag    = rt_neg ? -bus.rt_val : bus.rt_val;

        prod_fix  = neg_q ? -{core_hi, core_lo} : {core_hi, core_lo};
        quo_fix   = neg_q ? -core_lo : core_lo;
        rem_fix   = rem_neg_q ? -core_hi : core_hi;

        state_d    = state_q;
        cnt_d      = cnt_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        is_div_d   = is_div_q;
        neg_d      = neg_q;
        rem_neg_d  = rem_neg_q;
        core_load  = 1'b0;
        core_step  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (fire) begin
                    case (bus.op_func)
                        FN_MULT, FN_MULTU: begin
                            core_load = 1'b1;
                            is_div_d  = 1'b0;
                            neg_d     = rs_neg ^ rt_neg;
                            rem_neg_d = 1'b0;
                            cnt_d     = CW'(WIDTH - 1);
                            state_d   = ST_RUN;
                        end
                        FN_DIV, FN_DIVU: begin
                            // Divide by zero never iterates: fixed result, unit stays free.
                            if (bus.rt_val == '0) begin
                                hi_d = bus.rs_val;
                                lo_d = '1;
                            end else begin
                                core_load = 1'b1;
                                is_div_d  = 1'b1;
                                neg_d     = rs_neg ^ rt_neg;
                                rem_neg_d = rs_neg;
                                cnt_d     = CW'(WIDTH - 1);
                                state_d   = ST_RUN;
                            end
                        end
                        FN_MFHI: begin
                            rd_data_d  = hi_q;
                            rd_valid_d = 1'b1;
                        end
                        FN_MFLO: begin
                            rd_data_d  = lo_q;
                            rd_valid_d = 1'b1;
                        end
                        FN_MTHI: hi_d = bus.rs_val;
                        FN_MTLO: lo_d = bus.rs_val;
                        default: ;
                    endcase
                end
            end
            ST_RUN: begin
                core_step = 1'b1;
                cnt_d     = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    state_d = ST_FIXUP;
                end
            end
            ST_FIXUP: begin
                if (is_div_q) begin
                    lo_d = quo_fix;
                    hi_d = rem_fix;
                end else begin
                    {hi_d, lo_d} = prod_fix;
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d  = (state_d != ST_IDLE);
        ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            ready_q    <= 1'b1;
            is_div_q   <= 1'b0;
            neg_q      <= 1'b0;
            rem_neg_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            busy_q     <= busy_d;
            ready_q    <= ready_d;
            is_div_q   <= is_div_d;
            neg_q      <= neg_d;
            rem_neg_q  <= rem_neg_d;
        end
    end

    assign bus.op_ready = ready_q;
    assign bus.stall    = bus.op_valid & bus.enable_execute & ~ready_q;
    assign bus.busy     = busy_q;
    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;
endmodule

// File: tb/tb_muldiv_hilo_ctrl.sv
// Randomized + directed bench for muldiv_hilo_ctrl against an arithmetic HI/LO reference model.
module tb_muldiv_hilo_ctrl;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam int         LAT     = 33;

    logic clock = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    muldiv_hilo_ctrl_if #(.WIDTH(32)) bus ();

    muldiv_hilo_ctrl #(.WIDTH(32)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
        end
    endtask

    function automatic void model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, sp;
        logic [63:0] up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (f)
            F_MULT:  begin sp = sa * sb; {m_hi, m_lo} = sp; end
            F_MULTU: begin up = {32'd0, a} * {32'd0, b}; {m_hi, m_lo} = up; end
            F_DIV: begin
                if (b == 0) begin m_hi = a; m_lo = '1; end
                else begin m_lo = 32'(sa / sb); m_hi = 32'(sa % sb); end
            end
            F_DIVU: begin
                if (b == 0) begin m_hi = a; m_lo = '1; end
                else begin m_lo = a / b; m_hi = a % b; end
            end
            F_MTHI: m_hi = a;
            F_MTLO: m_lo = a;
            default: ;
        endcase
    endfunction

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            4: return 32'($urandom_range(0, 20));
            5: return -32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    // Present an op, wait (bounded) for acceptance, return at the negedge after the fire edge.
    task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        int n;
        bus.enable_execute = 1'b1;
        bus.op_valid = 1'b1;
        bus.op_func  = f;
        bus.rs_val   = a;
        bus.rt_val   = b;
        n = 0;
        while (!bus.op_ready && n < 100) begin
            @(negedge clock);
            n++;
        end
        if (n >= 100) check("accept_timeout", 64'd0, 64'd1);
        @(negedge clock);
        bus.op_valid = 1'b0;
    endtask

    task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        int          cyc;
        logic        is_long;
        logic [31:0] exp_rd;
        is_long = (f == F_MULT) || (f == F_MULTU) || (((f == F_DIV) || (f == F_DIVU)) && (b != 0));
        exp_rd  = (f == F_MFHI) ? m_hi : m_lo;
        model(f, a, b);
        issue(f, a, b);
        if (is_long) begin
            cyc = 0;
            while (bus.busy && cyc < 100) begin
                cyc++;
                bus.enable_execute = 1'($urandom_range(0, 1));
                @(negedge clock);
            end
            check("busy_cycles", 64'(cyc), 64'(LAT));
            check("ready_after", 64'(bus.op_ready), 64'd1);
        end else begin
            check("no_busy", 64'({bus.busy, bus.op_ready}), 64'b01);
            if (f == F_MFHI || f == F_MFLO) begin
                check("rd_valid", 64'(bus.rd_valid), 64'd1);
                check("rd_data", 64'(bus.rd_data), 64'(exp_rd));
                @(negedge clock);
                check("rd_pulse", 64'(bus.rd_valid), 64'd0);
            end else begin
                check("rd_quiet", 64'(bus.rd_valid), 64'd0);
            end
        end
        check("hi", 64'(bus.hi), 64'(m_hi));
        check("lo", 64'(bus.lo), 64'(m_lo));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int          stall_cnt, cyc;
        logic [5:0]  funcs [9];
        logic [5:0]  f;
        logic [31:0] a, b;
        funcs = '{F_MULT, F_MULTU, F_DIV, F_DIVU, F_MFHI, F_MFLO, F_MTHI, F_MTLO, F_ADD};

        reset = 1'b1;
        bus.enable_execute = 1'b0;
        bus.op_valid = 1'b0;
        bus.op_func  = '0;
        bus.rs_val   = '0;
        bus.rt_val   = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        check("rst_hi", 64'(bus.hi), 64'd0);
        check("rst_lo", 64'(bus.lo), 64'd0);
        check("rst_rd", 64'({bus.rd_data, bus.rd_valid}), 64'd0);
        check("rst_busy_ready", 64'({bus.busy, bus.op_ready}), 64'b01);

        run_op(F_MULT, 32'hFFFF_FFFD, 32'd7);
        check("mult_neg_hi", 64'(bus.hi), 64'hFFFF_FFFF);
        check("mult_neg_lo", 64'(bus.lo), 64'hFFFF_FFEB);
        run_op(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("multu_max", {32'(bus.hi), 32'(bus.lo)}, 64'hFFFF_FFFE_0000_0001);
        run_op(F_DIV, -32'd7, 32'd2);
        check("div_neg", {32'(bus.hi), 32'(bus.lo)}, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op(F_DIVU, 32'd100, 32'd7);
        check("divu", {32'(bus.hi), 32'(bus.lo)}, {32'd2, 32'd14});
        run_op(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        check("div_ovf", {32'(bus.hi), 32'(bus.lo)}, 64'h0000_0000_8000_0000);
        run_op(F_DIVU, 32'd5, 32'd0);
        check("divz", {32'(bus.hi), 32'(bus.lo)}, 64'h0000_0005_FFFF_FFFF);
        run_op(F_MTHI, 32'h1234, 32'd0);
        run_op(F_MFHI, 32'd0, 32'd0);
        check("mthi_mfhi", 64'(bus.rd_data), 64'h1234);
        run_op(F_ADD, 32'h5555, 32'h6666);

        // MFLO held behind an in-flight DIV: stalls for the whole busy span, then reads new LO.
        model(F_DIV, 32'd1000, -32'd3);
        bus.enable_execute = 1'b1;
        bus.op_valid = 1'b1;
        bus.op_func  = F_DIV;
        bus.rs_val   = 32'd1000;
        bus.rt_val   = -32'd3;
        @(negedge clock);
        bus.op_func = F_MFLO;
        stall_cnt = 0;
        cyc = 0;
        while (!bus.op_ready && cyc < 100) begin
            if (bus.stall) stall_cnt++;
            cyc++;
            @(negedge clock);
        end
        check("mflo_stall_cycles", 64'(stall_cnt), 64'(LAT));
        check("mflo_stall_drop", 64'(bus.stall), 64'd0);
        @(negedge clock);
        bus.op_valid = 1'b0;
        check("mflo_rd_valid", 64'(bus.rd_valid), 64'd1);
        check("mflo_rd_data", 64'(bus.rd_data), 64'(m_lo));
        @(negedge clock);
        check("mflo_pulse", 64'(bus.rd_valid), 64'd0);

        // enable_execute low: nothing accepted, no stall.
        bus.enable_execute = 1'b0;
        bus.op_valid = 1'b1;
        bus.op_func  = F_MTHI;
        bus.rs_val   = 32'hDEAD_BEEF;
        repeat (3) begin
            @(negedge clock);
            check("en0_stall", 64'(bus.stall), 64'd0);
        end
        check("en0_hi", 64'(bus.hi), 64'(m_hi));
        bus.op_valid = 1'b0;

        for (int i = 0; i < 60; i++) begin
            f = funcs[$urandom_range(0, 8)];
            a = rnd_val();
            b = ($urandom_range(0, 7) == 0) ? 32'd0 : rnd_val();
            run_op(f, a, b);
        end

        // Reset during RUN cycle 10 abandons the op.
        run_op(F_MTLO, 32'hCAFE_F00D, 32'd0);
        issue(F_MULT, 32'd12345, 32'd678);
        repeat (9) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        m_hi = '0;
        m_lo = '0;
        check("midrst_hilo", {32'(bus.hi), 32'(bus.lo)}, 64'd0);
        check("midrst_busy_ready", 64'({bus.busy, bus.op_ready}), 64'b01);
        run_op(F_MULTU, 32'd3, 32'd5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
